// File: rtl/mem_stage_pkg.sv
// Shared load/store type codes, FSM state encoding and reset PC for the memory stage.
package mem_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  localparam logic [2:0] LS_LW  = 3'd0;
  localparam logic [2:0] LS_LB  = 3'd1;
  localparam logic [2:0] LS_LBU = 3'd2;
  localparam logic [2:0] LS_LH  = 3'd3;
  localparam logic [2:0] LS_LHU = 3'd4;
  localparam logic [2:0] LS_LWL = 3'd5;
  localparam logic [2:0] LS_LWR = 3'd6;

  localparam logic [2:0] LS_SW  = 3'd0;
  localparam logic [2:0] LS_SB  = 3'd1;
  localparam logic [2:0] LS_SH  = 3'd2;
  localparam logic [2:0] LS_SWL = 3'd5;
  localparam logic [2:0] LS_SWR = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/memory_stage_load_align.sv
// Combinational load alignment: byte/half select with sign/zero extension.
// LWL/LWR merging with the old rt value is built only with MEM_UNALIGNED_EN.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ls_type,
  input  logic [31:0] old_rt,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

`ifndef MEM_UNALIGNED_EN
  logic unused_old_rt;
  assign unused_old_rt = ^old_rt;
`endif

  always_comb begin
    value = rdata;
    case (ls_type)
      LS_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      LS_LBU:  value = {24'h000000, byte_sel};
      LS_LH:   value = {{16{half_sel[15]}}, half_sel};
      LS_LHU:  value = {16'h0000, half_sel};
`ifdef MEM_UNALIGNED_EN
      // Little-endian merge: LWL fills the high bytes, LWR the low bytes.
      LS_LWL: begin
        case (addr_lo)
          2'd0:    value = {rdata[7:0],  old_rt[23:0]};
          2'd1:    value = {rdata[15:0], old_rt[15:0]};
          2'd2:    value = {rdata[23:0], old_rt[7:0]};
          default: value = rdata;
        endcase
      end
      LS_LWR: begin
        case (addr_lo)
          2'd0:    value = rdata;
          2'd1:    value = {old_rt[31:24], rdata[31:8]};
          2'd2:    value = {old_rt[31:16], rdata[31:16]};
          default: value = {old_rt[31:8],  rdata[31:24]};
        endcase
      end
`endif
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: stage register, data-SRAM handshake FSM and load alignment.
// Optional LWL/LWR/SWL/SWR support is enabled by defining MEM_UNALIGNED_EN.
module memory_stage #(
  parameter logic [31:0] RESET_PC = mem_stage_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_wait,
  input  logic        exe_valid,
  input  logic [31:0] exe_pc,
  input  logic        exe_Reg_write,
  input  logic [4:0]  exe_dest,
  input  logic [31:0] exe_alu_result,
  input  logic        exe_mem_read,
  input  logic        exe_mem_write,
  input  logic [2:0]  exe_ls_type,
  input  logic [31:0] exe_store_data,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_busy,
  output logic        mem_invalid,
  output logic        mem_out_Reg_write,
  output logic [4:0]  mem_dest,
  output logic [31:0] mem_value,
  output logic [31:0] debug_pc_mem_out
);
  import mem_stage_pkg::*;

  mem_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] alu_q, alu_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  ls_type_q, ls_type_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        load_en;
  logic        in_req;
  logic [1:0]  req_size;
  logic [3:0]  req_strb;
  logic [31:0] req_wdata;
  logic [31:0] load_value;

  assign mem_busy = (state_q == ST_REQ) || (state_q == ST_RESP);
  assign load_en  = !inst_wait && !mem_busy;
  assign in_req   = (state_q == ST_REQ);

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    reg_write_d  = reg_write_q;
    dest_d       = dest_q;
    alu_d        = alu_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    ls_type_d    = ls_type_q;
    store_data_d = store_data_q;
    if (load_en) begin
      valid_d      = exe_valid;
      pc_d         = exe_pc;
      reg_write_d  = exe_Reg_write;
      dest_d       = exe_dest;
      alu_d        = exe_alu_result;
      mem_read_d   = exe_mem_read;
      mem_write_d  = exe_mem_write;
      ls_type_d    = exe_ls_type;
      store_data_d = exe_store_data;
    end
  end

  // inst_wait only freezes capture; an outstanding access keeps progressing.
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    case (state_q)
      ST_REQ: begin
        if (data_addr_ok) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (data_data_ok) begin
          state_d = ST_DONE;
          if (mem_read_q) rdata_buf_d = data_rdata;
        end
      end
      default: begin
        if (load_en) begin
          state_d = (exe_valid && (exe_mem_read || exe_mem_write)) ? ST_REQ : ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      pc_q         <= RESET_PC;
      reg_write_q  <= 1'b0;
      dest_q       <= 5'd0;
      alu_q        <= 32'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ls_type_q    <= 3'd0;
      store_data_q <= 32'd0;
      rdata_buf_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      reg_write_q  <= reg_write_d;
      dest_q       <= dest_d;
      alu_q        <= alu_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ls_type_q    <= ls_type_d;
      store_data_q <= store_data_d;
      rdata_buf_q  <= rdata_buf_d;
    end
  end

  // Load codes 1..4 and store codes 1..2 are sub-word; everything else is a word access.
  always_comb begin
    req_size  = 2'd2;
    req_strb  = 4'b0000;
    req_wdata = 32'd0;
    if (mem_write_q) begin
      req_strb  = 4'b1111;
      req_wdata = store_data_q;
      case (ls_type_q)
        LS_SB: begin
          req_size  = 2'd0;
          req_strb  = 4'b0001 << alu_q[1:0];
          req_wdata = {4{store_data_q[7:0]}};
        end
        LS_SH: begin
          req_size  = 2'd1;
          req_strb  = 4'b0011 << {alu_q[1], 1'b0};
          req_wdata = {2{store_data_q[15:0]}};
        end
`ifdef MEM_UNALIGNED_EN
        LS_SWL: begin
          req_strb  = 4'b1111 >> (2'd3 - alu_q[1:0]);
          req_wdata = store_data_q >> {(2'd3 - alu_q[1:0]), 3'b000};
        end
        LS_SWR: begin
          req_strb  = 4'b1111 << alu_q[1:0];
          req_wdata = store_data_q << {alu_q[1:0], 3'b000};
        end
`endif
        default: ;
      endcase
    end else begin
      case (ls_type_q)
        LS_LB, LS_LBU: req_size = 2'd0;
        LS_LH, LS_LHU: req_size = 2'd1;
        default:       req_size = 2'd2;
      endcase
    end
  end

  assign data_req   = in_req;
  assign data_wr    = in_req && mem_write_q;
  assign data_size  = in_req ? req_size : 2'd0;
  assign data_addr  = !in_req ? 32'd0 :
                      (req_size == 2'd2) ? {alu_q[31:2], 2'b00} : alu_q;
  assign data_wdata = in_req ? req_wdata : 32'd0;
  assign data_wstrb = in_req ? req_strb : 4'b0000;

  load_align u_load_align (
    .rdata   (rdata_buf_q),
    .addr_lo (alu_q[1:0]),
    .ls_type (ls_type_q),
    .old_rt  (store_data_q),
    .value   (load_value)
  );

  assign mem_invalid       = !valid_q || mem_busy;
  assign mem_out_Reg_write = valid_q && reg_write_q && !mem_invalid;
  assign mem_dest          = dest_q;
  assign mem_value         = mem_read_q ? load_value : alu_q;
  assign debug_pc_mem_out  = pc_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the five-stage MIPS pipeline, between the execute stage and `writeback_stage`. Latches execute results, runs the data-SRAM request/response handshake for loads and stores, aligns and sign-extends load data, and presents destination, value and write-enable to writeback. While a memory access is outstanding it stalls upstream and sends a bubble downstream.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc00000, reset value of `debug_pc_mem_out`.

Ports. One clock; reset is synchronous and active-high.
- `clk` input 1: clock.
- `rst` input 1: synchronous active-high reset.
- `inst_wait` input 1: global freeze; the stage register holds.
- `exe_valid` input 1: the execute output carries a real instruction.
- `exe_pc` input 32: instruction PC.
- `exe_Reg_write` input 1: the instruction writes the register file.
- `exe_dest` input 5: destination register.
- `exe_alu_result` input 32: ALU result, or the effective address for memory ops.
- `exe_mem_read` / `exe_mem_write` input 1 each: load or store; never both high.
- `exe_ls_type` input 3: load/store type code (package constants).
- `exe_store_data` input 32: rt value for stores; old rt value for LWL/LWR merges.
- `data_req` output 1, `data_wr` output 1, `data_size` output 2, `data_addr` output 32, `data_wdata` output 32, `data_wstrb` output 4: data-SRAM request.
- `data_addr_ok` input 1, `data_data_ok` input 1, `data_rdata` input 32: data-SRAM acceptance, response and read data.
- `mem_busy` output 1: upstream must hold the execute output.
- `mem_invalid` output 1: the current output is a bubble.
- `mem_out_Reg_write` output 1, `mem_dest` output 5, `mem_value` output 32, `debug_pc_mem_out` output 32: to writeback.

## Operation
- Stage register loads the `exe_*` inputs on a clock edge when `!rst && !inst_wait && !mem_busy`. Otherwise it holds.
- FSM states: IDLE, REQ, RESP, DONE.
  - When a load or store is captured, the next state is REQ. Any other instruction goes to IDLE.
  - REQ: `data_req`=1. On `data_addr_ok`, go to RESP.
  - RESP: on `data_data_ok`, go to DONE. Loads capture `data_rdata` into `rdata_buf`. Stores ignore `data_rdata`.
  - DONE and IDLE: the stage output is valid.
- `mem_busy` = state is REQ or RESP.
- `mem_invalid` = `!stage_valid` or state is REQ/RESP.
- `mem_out_Reg_write` = `stage_valid && Reg_write && !mem_invalid`.
- `mem_value`:
  - Non-loads: the ALU result.
  - Loads: the aligned `rdata_buf`.
- Load types by `addr[1:0]`:
  - LW: the full word.
  - LB/LBU: the selected byte, sign- or zero-extended.
  - LH/LHU: the half at `addr[1]`, sign- or zero-extended.
- Stores:
  - `data_size`: SB=0, SH=1, SW=2.
  - `data_wstrb`: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<{addr[1],1'b0}; SW gives 4'b1111.
  - `data_wdata`: rt replicated across byte or half lanes.
- `data_addr`: `{addr[31:2],2'b00}` for SW/LW and LWL/LWR; the byte address otherwise.
- Misaligned LW/LH/SW/SH are handled by the exception logic upstream. This stage never receives them.

## Timing
- Reset values: `data_req`=0, `data_wr`=0, `data_size`=0, `data_addr`=0, `data_wdata`=0, `data_wstrb`=0, `mem_busy`=0, `mem_invalid`=1, `mem_out_Reg_write`=0, `mem_dest`=0, `mem_value`=0, `debug_pc_mem_out`=`RESET_PC`. The FSM resets to IDLE.
- Non-memory instruction: outputs are valid in the cycle after capture, with zero added latency.
- Memory op with `data_addr_ok` in the first REQ cycle and `data_data_ok` in the next cycle:
  - Capture at edge T.
  - `data_req` high during T.
  - RESP during T+1.
  - Output valid during T+2.
- `data_req` stays high with stable address, data and strobe until `data_addr_ok`. A second request is never issued before `data_data_ok`.
- `inst_wait` does not block the FSM: REQ/RESP progress continues.
  - If `data_data_ok` and `inst_wait` arrive together, `rdata_buf` still captures and the FSM enters DONE, which holds until a new capture.
- `data_data_ok` in IDLE, REQ or DONE is ignored.
- Reset mid-access: the FSM returns to IDLE. The SRAM shares `rst`, so no stale response follows.

## Configuration
- `MEM_UNALIGNED_EN` defined:
  - LWL/LWR are decoded.
  - `data_size`=2 at the aligned address.
  - The result merges rdata bytes with `exe_store_data` per MIPS little-endian rules. Example: LWL at addr[1:0]=0 gives `{rdata[7:0], rt[23:0]}`; LWR at 3 gives `{rt[31:8], rdata[31:24]}`.
  - SWL/SWR produce shifted wdata with matching strobes.
- `MEM_UNALIGNED_EN` undefined: those type codes are treated as LW/SW.

## Structure
- Package `mem_stage_pkg` holds:
  - Load/store type codes: LW=0, LB=1, LBU=2, LH=3, LHU=4, LWL=5, LWR=6, SW=0, SB=1, SH=2, SWL=5, SWR=6.
  - The FSM state enum.
  - `RESET_PC`.
- Sub-module `load_align` is purely combinational: inputs are rdata, addr[1:0], type and old rt; output is the aligned value. The `MEM_UNALIGNED_EN` merge logic lives in it.

## Test plan
- ADD result 32'h1234 to $5 → the next cycle shows `mem_value`=32'h1234, `mem_dest`=5, `mem_out_Reg_write`=1, `mem_busy`=0.
- LB at addr 32'h...03, rdata 32'h80FF_FF7F, with `data_addr_ok`/`data_data_ok` 2 cycles late each → `mem_busy` high throughout, then `mem_value`=32'hFFFF_FF80. LBU on the same access gives 32'h0000_0080.
- SH at addr 2, rt 32'hAAAA_BEEF → `data_wstrb`=4'b1100, `data_wdata`=32'hBEEF_BEEF, `data_size`=1. `mem_out_Reg_write`=0.
- `inst_wait` high coincident with `data_data_ok` on LW, rdata 32'hCAFE_F00D → the value is kept; after `inst_wait` drops, `mem_value`=32'hCAFE_F00D and the PC is unchanged.
- `rst` asserted in RESP → the next cycle is IDLE, all outputs at reset values, and a later stray `data_data_ok` is ignored.
- With `MEM_UNALIGNED_EN`: LWL addr 1, rdata 32'h4433_2211, rt 32'hDDCC_BBAA → 32'h2211_BBAA.
